// File: rtl/axioma_trace_pkg.sv
// rtl/axioma_trace_pkg.sv - shared encodings and entry sizing for the PC trace buffer
package axioma_trace_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_STOP = 2'd1,
        MODE_TRIG = 2'd2,
        MODE_RSVD = 2'd3
    } trace_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    // Entry layout is {timestamp, pc, instr, irq}
    function automatic int entry_width(input int ts_w, input int pc_w, input int instr_w);
        return ts_w + pc_w + instr_w + 1;
    endfunction

endpackage

// File: rtl/axioma_trace_fifo.sv
// rtl/axioma_trace_fifo.sv - circular trace store with push, pop and overwrite-oldest
module axioma_trace_fifo
    import axioma_trace_pkg::*;
#(
    parameter int W     = 49,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;
    logic          drop_oldest;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

    // A push into a full store is accepted when a pop frees the slot or overwrite is allowed
    always_comb begin
        do_pop      = pop && !empty;
        do_push     = push && (!full || do_pop || overwrite);
        drop_oldest = do_push && full && !do_pop;
    end

    // Pointer and occupancy bookkeeping; clear flushes everything in one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || drop_oldest) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop && !drop_oldest) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents are never read while empty so they need no reset
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/axioma_pc_trace.sv
// rtl/axioma_pc_trace.sv - CPU program-counter trace capture with wrap, stop and trigger modes
module axioma_pc_trace
    import axioma_trace_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          capture_en,
    input  logic [1:0]                    mode,
    input  logic                          clear,
    input  logic [PC_W-1:0]               trig_pc,
    input  logic [$clog2(DEPTH):0]        post_count,
    input  logic [PC_W-1:0]               pc_in,
    input  logic [INSTR_W-1:0]            instr_in,
    input  logic                          irq_in,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [TS_W+PC_W+INSTR_W:0]    rd_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overrun,
    output logic [7:0]                    dropped,
    output logic [1:0]                    state
);

    localparam int ENTRY_W = entry_width(TS_W, PC_W, INSTR_W);
    localparam int CW      = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] last_pc;
    logic [TS_W-1:0] ts;
    logic            cap_q;
    trace_state_t    trig_state;
    trace_state_t    trig_next;
    logic [CW-1:0]   post_rem;
    logic [CW-1:0]   post_rem_next;
    trace_mode_t     eff_mode;
    logic            cap_evt;
    logic            pop;
    logic            full;
    logic            empty;
    logic            push;
    logic            overwrite;
    logic            set_overrun;
    logic            inc_drop;

    assign cap_evt  = capture_en && (pc_in != last_pc);
    assign pop      = rd_valid && rd_ready;
    assign eff_mode = (mode == MODE_RSVD) ? MODE_STOP : trace_mode_t'(mode);
    assign rd_valid = !empty;
    assign state    = (eff_mode == MODE_TRIG) ? trig_state
                                              : (capture_en ? ST_ARMED : ST_IDLE);

    // Change detector, free-running timestamp and capture_en edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pc <= '0;
            ts      <= '0;
            cap_q   <= 1'b0;
        end else begin
            last_pc <= pc_in;
            ts      <= ts + 1'b1;
            cap_q   <= capture_en;
        end
    end

    // Sticky overrun flag and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
            dropped <= '0;
        end else if (clear) begin
            overrun <= 1'b0;
            dropped <= '0;
        end else begin
            if (set_overrun) begin
                overrun <= 1'b1;
            end
            if (inc_drop && (dropped != 8'hFF)) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

    // Trigger state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_state <= ST_IDLE;
            post_rem   <= '0;
        end else begin
            trig_state <= trig_next;
            post_rem   <= post_rem_next;
        end
    end

    // Per-mode capture policy and trigger sequencing
    always_comb begin
        trig_next     = trig_state;
        post_rem_next = post_rem;
        push          = 1'b0;
        overwrite     = 1'b0;
        set_overrun   = 1'b0;
        inc_drop      = 1'b0;
        case (eff_mode)
            MODE_WRAP: begin
                push        = cap_evt;
                overwrite   = 1'b1;
                set_overrun = cap_evt && full && !pop;
                trig_next   = ST_IDLE;
            end
            MODE_TRIG: begin
                case (trig_state)
                    ST_IDLE: begin
                        if (capture_en && !cap_q) begin
                            trig_next = ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        push      = cap_evt;
                        overwrite = 1'b1;
                        if (cap_evt && (pc_in == trig_pc)) begin
                            post_rem_next = post_count;
                            trig_next     = (post_count == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        push      = cap_evt;
                        overwrite = 1'b1;
                        if (cap_evt) begin
                            post_rem_next = post_rem - 1'b1;
                            if (post_rem == CW'(1)) begin
                                trig_next = ST_DONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                push      = cap_evt;
                inc_drop  = cap_evt && full && !pop;
                trig_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            trig_next = ST_IDLE;
        end
    end

    axioma_trace_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .overwrite (overwrite),
        .wdata     ({ts, pc_in, instr_in, irq_in}),
        .rdata     (rd_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_axioma_pc_trace.sv
// tb/tb_axioma_pc_trace.sv - directed scoreboard bench for axioma_pc_trace
module tb_axioma_pc_trace;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;
    localparam int TS_W    = 8;
    localparam int CW      = 3;
    localparam int EW      = TS_W + PC_W + INSTR_W + 1;
    localparam int P_WRAP  = 0;
    localparam int P_STOP  = 1;
    localparam int P_ARM   = 2;
    localparam int P_IGN   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               capture_en;
    logic [1:0]         mode;
    logic               clear;
    logic [PC_W-1:0]    trig_pc;
    logic [CW-1:0]      post_count;
    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               irq_in;
    logic               rd_valid;
    logic               rd_ready;
    logic [EW-1:0]      rd_data;
    logic [CW-1:0]      count;
    logic               overrun;
    logic [7:0]         dropped;
    logic [1:0]         state;

    logic [TS_W-1:0]    tb_ts;
    logic [EW-1:0]      q[$];
    logic               m_ovr;
    int                 m_drop;
    logic [PC_W-1:0]    m_last;
    int                 n_vec;
    int                 n_err;
    logic [TS_W-1:0]    ts1;
    logic [TS_W-1:0]    ts2;

    axioma_pc_trace #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .TS_W    (TS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .mode       (mode),
        .clear      (clear),
        .trig_pc    (trig_pc),
        .post_count (post_count),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .irq_in     (irq_in),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .count      (count),
        .overrun    (overrun),
        .dropped    (dropped),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample_all(input string tag);
        check({tag, ".valid"}, 64'(rd_valid), 64'(q.size() != 0));
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        check({tag, ".ovr"},   64'(overrun), 64'(m_ovr));
        check({tag, ".drop"},  64'(dropped), 64'(m_drop));
        check({tag, ".data"},  64'(rd_data), (q.size() != 0) ? 64'(q[0]) : 64'(0));
    endtask

    task automatic cyc(input logic [PC_W-1:0] pc, input logic en, input logic rdy,
                       input int pol, input logic clr, input string tag);
        logic [EW-1:0] ent;
        logic          evt;
        logic          dopop;
        pc_in      = pc;
        instr_in   = pc ^ 16'h5A00;
        irq_in     = pc[0];
        capture_en = en;
        rd_ready   = rdy;
        clear      = clr;
        evt   = en && (pc != m_last);
        ent   = {tb_ts, pc, pc ^ 16'h5A00, pc[0]};
        dopop = rdy && (q.size() != 0);
        m_last = pc;
        if (clr) begin
            q.delete();
            m_ovr  = 1'b0;
            m_drop = 0;
        end else begin
            if (dopop) void'(q.pop_front());
            if (evt) begin
                case (pol)
                    P_WRAP, P_ARM: begin
                        if (q.size() == DEPTH) begin
                            void'(q.pop_front());
                            if (pol == P_WRAP) m_ovr = 1'b1;
                        end
                        q.push_back(ent);
                    end
                    P_STOP: begin
                        if (q.size() == DEPTH) begin
                            if (m_drop < 255) m_drop++;
                        end else begin
                            q.push_back(ent);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
        @(negedge clk);
        clear = 1'b0;
        sample_all(tag);
    endtask

    task automatic pop_expect(input string tag, input logic [PC_W-1:0] exp_pc,
                              input logic [PC_W-1:0] hold_pc);
        check({tag, ".pc"}, 64'(rd_data[INSTR_W+1 +: PC_W]), 64'(exp_pc));
        cyc(hold_pc, 1'b0, 1'b1, P_IGN, 1'b0, tag);
    endtask

    initial begin
        int g;
        n_vec = 0; n_err = 0;
        m_last = '0; m_ovr = 1'b0; m_drop = 0;
        reset = 1'b1; capture_en = 1'b0; mode = 2'd0; clear = 1'b0;
        trig_pc = '0; post_count = '0; pc_in = '0; instr_in = '0;
        irq_in = 1'b0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        sample_all("rst");
        check("rst.state", 64'(state), 64'(0));
        reset = 1'b0;

        // V1: wrap mode overwrites oldest
        mode = 2'd0;
        for (int i = 1; i <= 6; i++) cyc(PC_W'(i), 1'b1, 1'b0, P_WRAP, 1'b0, "v1.cap");
        check("v1.count", 64'(count), 64'(4));
        check("v1.ovr", 64'(overrun), 64'(1));
        check("v1.state_armed", 64'(state), 64'(1));
        for (int i = 3; i <= 6; i++) pop_expect("v1.pop", PC_W'(i), 16'd6);
        check("v1.state_idle", 64'(state), 64'(0));

        // V2: stop-when-full drops new captures
        mode = 2'd1;
        cyc(16'd6, 1'b0, 1'b0, P_IGN, 1'b1, "v2.clr");
        for (int i = 1; i <= 6; i++) cyc(PC_W'(i), 1'b1, 1'b0, P_STOP, 1'b0, "v2.cap");
        check("v2.drop", 64'(dropped), 64'(2));
        check("v2.ovr", 64'(overrun), 64'(0));
        for (int i = 1; i <= 4; i++) pop_expect("v2.pop", PC_W'(i), 16'd6);

        // V4: simultaneous capture and pop at full
        mode = 2'd0;
        for (int i = 7; i <= 10; i++) cyc(PC_W'(i), 1'b1, 1'b0, P_WRAP, 1'b0, "v4.fill");
        cyc(16'd11, 1'b1, 1'b1, P_WRAP, 1'b0, "v4.both");
        check("v4.count", 64'(count), 64'(4));
        check("v4.ovr", 64'(overrun), 64'(0));
        for (int i = 8; i <= 11; i++) pop_expect("v4.pop", PC_W'(i), 16'd11);

        // V3: trigger mode with two post-trigger entries
        mode = 2'd2; trig_pc = 16'h0010; post_count = 3'd2;
        cyc(16'h000D, 1'b0, 1'b0, P_IGN, 1'b1, "v3.clr");
        check("v3.idle", 64'(state), 64'(0));
        cyc(16'h000D, 1'b1, 1'b0, P_IGN, 1'b0, "v3.rise");
        check("v3.armed", 64'(state), 64'(1));
        cyc(16'h000E, 1'b1, 1'b0, P_ARM, 1'b0, "v3.cap");
        cyc(16'h000F, 1'b1, 1'b0, P_ARM, 1'b0, "v3.cap");
        cyc(16'h0010, 1'b1, 1'b0, P_ARM, 1'b0, "v3.trig");
        check("v3.post", 64'(state), 64'(2));
        cyc(16'h0011, 1'b1, 1'b0, P_ARM, 1'b0, "v3.cap");
        check("v3.post2", 64'(state), 64'(2));
        cyc(16'h0012, 1'b1, 1'b0, P_ARM, 1'b0, "v3.last");
        check("v3.done", 64'(state), 64'(3));
        cyc(16'h0013, 1'b1, 1'b0, P_IGN, 1'b0, "v3.ign");
        check("v3.done2", 64'(state), 64'(3));
        check("v3.ovr", 64'(overrun), 64'(0));
        pop_expect("v3.pop", 16'h000F, 16'h0013);
        pop_expect("v3.pop", 16'h0010, 16'h0013);
        pop_expect("v3.pop", 16'h0011, 16'h0013);
        pop_expect("v3.pop", 16'h0012, 16'h0013);
        check("v3.empty", 64'(count), 64'(0));

        // post_count = 0: trigger entry goes straight to DONE
        post_count = 3'd0;
        cyc(16'h0012, 1'b0, 1'b0, P_IGN, 1'b1, "v3z.clr");
        cyc(16'h0012, 1'b1, 1'b0, P_IGN, 1'b0, "v3z.rise");
        cyc(16'h0010, 1'b1, 1'b0, P_ARM, 1'b0, "v3z.trig");
        check("v3z.done", 64'(state), 64'(3));
        cyc(16'h0011, 1'b1, 1'b0, P_IGN, 1'b0, "v3z.ign");
        pop_expect("v3z.pop", 16'h0010, 16'h0011);

        // V5: held PC yields one entry; timestamp deltas with and without wrap
        mode = 2'd0;
        cyc(16'h0011, 1'b0, 1'b0, P_IGN, 1'b1, "v5.clr");
        for (int i = 0; i < 10; i++) cyc(16'h0020, 1'b1, 1'b0, P_WRAP, 1'b0, "v5.hold");
        check("v5.one", 64'(count), 64'(1));
        cyc(16'h0020, 1'b0, 1'b1, P_WRAP, 1'b0, "v5.drain");
        cyc(16'h0030, 1'b1, 1'b0, P_WRAP, 1'b0, "v5.a");
        for (int i = 0; i < 4; i++) cyc(16'h0030, 1'b1, 1'b0, P_WRAP, 1'b0, "v5.a");
        cyc(16'h0031, 1'b1, 1'b0, P_WRAP, 1'b0, "v5.b");
        ts1 = rd_data[EW-1 -: TS_W];
        cyc(16'h0031, 1'b0, 1'b1, P_WRAP, 1'b0, "v5.pop");
        ts2 = rd_data[EW-1 -: TS_W];
        check("v5.delta", 64'(ts2 - ts1), 64'(5));
        cyc(16'h0031, 1'b0, 1'b1, P_WRAP, 1'b0, "v5.pop");
        g = 0;
        while (tb_ts != 8'd253 && g < 300) begin
            cyc(16'h0031, 1'b0, 1'b0, P_WRAP, 1'b0, "v5.wait");
            g++;
        end
        check("v5.wait_bound", 64'(g < 300), 64'(1));
        cyc(16'h0040, 1'b1, 1'b0, P_WRAP, 1'b0, "v5.wa");
        for (int i = 0; i < 4; i++) cyc(16'h0040, 1'b1, 1'b0, P_WRAP, 1'b0, "v5.wa");
        cyc(16'h0041, 1'b1, 1'b0, P_WRAP, 1'b0, "v5.wb");
        ts1 = rd_data[EW-1 -: TS_W];
        cyc(16'h0041, 1'b0, 1'b1, P_WRAP, 1'b0, "v5.wpop");
        ts2 = rd_data[EW-1 -: TS_W];
        check("v5.wrap_ts1", 64'(ts1), 64'(253));
        check("v5.wrap_ts2", 64'(ts2), 64'(2));
        check("v5.wrap_delta", 64'(TS_W'(ts2 - ts1)), 64'(5));
        cyc(16'h0041, 1'b0, 1'b1, P_WRAP, 1'b0, "v5.wpop");

        // V6: reset during readout, then clear during capture
        mode = 2'd0;
        cyc(16'h0041, 1'b0, 1'b0, P_IGN, 1'b1, "v6.clr");
        for (int i = 'h50; i <= 'h54; i++) cyc(PC_W'(i), 1'b1, 1'b0, P_WRAP, 1'b0, "v6.fill");
        mode = 2'd1;
        cyc(16'h0055, 1'b1, 1'b0, P_STOP, 1'b0, "v6.modechg");
        check("v6.ovr_pre", 64'(overrun), 64'(1));
        check("v6.drop_pre", 64'(dropped), 64'(1));
        pop_expect("v6.pop", 16'h0051, 16'h0055);
        rd_ready = 1'b0;
        #2 rd_ready = 1'b1;
        #1 reset = 1'b1;
        q.delete(); m_ovr = 1'b0; m_drop = 0; m_last = '0;
        @(negedge clk);
        rd_ready = 1'b0;
        @(negedge clk);
        rd_ready = 1'b1;
        sample_all("v6.in_rst");
        check("v6.state", 64'(state), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        cyc(16'h0000, 1'b1, 1'b1, P_STOP, 1'b0, "v6.lastpc");
        cyc(16'h0056, 1'b1, 1'b0, P_STOP, 1'b0, "v6.cap");
        cyc(16'h0057, 1'b1, 1'b0, P_STOP, 1'b1, "v6.clrcap");
        check("v6.clr_count", 64'(count), 64'(0));
        cyc(16'h0057, 1'b1, 1'b0, P_STOP, 1'b0, "v6.same");
        cyc(16'h0058, 1'b1, 1'b0, P_STOP, 1'b0, "v6.after");
        check("v6.after_count", 64'(count), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axioma_pc_trace.md
AXIOMA_PC_TRACE -- requirements
Module: axioma_pc_trace

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- PC_W, 16, program-counter width.
- INSTR_W, 16, instruction width.
- DEPTH, 16, trace entries; power of two, 4..256.
- TS_W, 16, timestamp width.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  core clock.
- reset  in  1  async active-high reset.
- capture_en  in  1  capture gate.
- mode  in  2  0=wrap, 1=stop-when-full, 2=trigger, 3=reserved (treated as 1).
- clear  in  1  synchronous flush.
- trig_pc  in  PC_W  trigger address.
- post_count  in  log2(DEPTH)+1  entries captured after trigger.
- pc_in  in  PC_W  CPU debug PC.
- instr_in  in  INSTR_W  CPU debug instruction.
- irq_in  in  1  interrupt-active flag.
- rd_valid  out  1  entry available.
- rd_ready  in  1  consumer accepts entry.
- rd_data  out  TS_W+PC_W+INSTR_W+1  {timestamp, pc, instr, irq}.
- count  out  log2(DEPTH)+1  entries stored.
- overrun  out  1  sticky; wrap mode overwrote an entry.
- dropped  out  8  saturating count of discarded captures.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.

Function
REQ-004 A capture event SHALL occur on a cycle where capture_en=1 and pc_in differs from last_pc; last_pc updates to pc_in every cycle, independent of capture_en.
REQ-005 The timestamp SHALL be a free-running TS_W cycle counter that wraps to 0 after all-ones; the entry stores its value on the capture cycle.
REQ-006 A captured entry SHALL appear at rd_data/rd_valid one cycle after the capture cycle; count SHALL update in the same cycle.
REQ-007 Readout SHALL pop the oldest entry on rd_valid&&rd_ready; rd_data SHALL hold stable while rd_valid=1 and rd_ready=0; rd_valid=0 whenever count=0.
REQ-008 Simultaneous capture and pop SHALL leave count unchanged at any fill level, including full, with no overrun and no drop.
REQ-009 Mode 0, full, capture without pop: oldest entry discarded, new entry written, count stays DEPTH, overrun set.
REQ-010 Mode 1, full, capture without pop: entry discarded, dropped increments (saturating at 255), contents unchanged.
REQ-011 Mode 2 state machine: IDLE->ARMED when capture_en rises; ARMED stores entries as mode 0 without setting overrun; ARMED->POST on a capture event with pc_in==trig_pc, that entry stored; POST stores post_count further entries, then ->DONE; DONE ignores captures (no drop count); clear->IDLE.
REQ-012 In mode 2 with post_count=0, the trigger entry SHALL move state directly to DONE.
REQ-013 In modes 0/1, state SHALL read ARMED while capture_en=1 and IDLE otherwise.
REQ-014 clear SHALL empty the buffer and zero count, overrun and dropped on the next edge; clear has priority over a simultaneous capture or pop; last_pc and timestamp are unaffected.
REQ-015 A mode change while count>0 SHALL not alter stored entries; the new mode applies from the next cycle.

Reset
REQ-016 Reset SHALL force rd_valid=0, count=0, overrun=0, dropped=0, state=IDLE, timestamp=0, last_pc=0 and pointers=0; rd_data reads 0.
REQ-017 Reset asserted mid-readout or mid-POST SHALL discard all entries, with no partial handshake completing after deassertion.

Structure
REQ-018 Package axioma_trace_pkg SHALL hold the mode and state encodings and the entry-width function.
REQ-019 Storage SHALL be one sub-module axioma_trace_fifo (parametrised circular buffer with push, pop, overwrite-oldest and count); capture and trigger control stay in the top.

Verification
REQ-020 Bench SHALL cover:
- V1 Mode 0, DEPTH=4, PC sequence 1,2,3,4,5,6 with rd_ready=0 -> count=4, overrun=1, pops yield PC 3,4,5,6.
- V2 Mode 1, DEPTH=4, same sequence -> pops yield PC 1,2,3,4; dropped=2.
- V3 Mode 2, trig_pc=0x0010, post_count=2, PCs 0x0E,0x0F,0x10,0x11,0x12,0x13 -> state DONE after 0x12; last three pops 0x10,0x11,0x12; 0x13 absent.
- V4 Full buffer with capture and pop on the same cycle -> count stays 4, overrun=0, oldest entry leaves, new entry is last.
- V5 pc_in held at 0x0020 for 10 cycles -> one entry only; timestamp delta between two captures 5 cycles apart equals 5, including across a TS_W wrap.
- V6 Reset pulse while rd_valid=1 and rd_ready toggling; then clear during capture -> all outputs at reset values, count=0.
